// File: rtl/queue_ctrl.sv
// queue_ctrl: moves deserializer words into the queue and schedules dequeues,
// sharing the queue's enqueue/dequeue port pair with enqueue priority.
module queue_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned THRESH = 6
) (
  input  logic              clock_10KHZ,
  input  logic              reset,
  input  logic              data_ready_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_out,
  output logic              enqueue_out,
  output logic [DATA_W-1:0] data_out,
  input  logic [LEN_W-1:0]  len_in,
  input  logic              drain_in,
  output logic              dequeue_out,
  output logic              stall_out
);

  localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] THRESH_L = LEN_W'(THRESH);

  typedef enum logic [1:0] {IDLE, ENQ, ACK} ing_state_t;
  typedef enum logic [1:0] {E_IDLE, E_DEQ, E_WAIT} egr_state_t;

  ing_state_t        ing_state, ing_next;
  egr_state_t        egr_state, egr_next;
  logic              sync_q, rdy_s;
  logic              full, can_enq, can_deq;
  logic [DATA_W-1:0] data_nxt;
  logic              stall_nxt;

  // Two-flop synchroniser for the deserializer's data_ready.
  always_ff @(posedge clock_10KHZ or negedge reset) begin
    if (!reset) begin
      sync_q <= 1'b0;
      rdy_s  <= 1'b0;
    end else begin
      sync_q <= data_ready_in;
      rdy_s  <= sync_q;
    end
  end

  // Next-state and next-output logic for both FSMs; enqueue wins the port.
  always_comb begin
    ing_next  = ing_state;
    egr_next  = egr_state;
    data_nxt  = data_out;
    full      = (len_in >= DEPTH_L);
    can_enq   = rdy_s && !full && (egr_state != E_DEQ);
    stall_nxt = (ing_state == IDLE) && rdy_s && full;

    unique case (ing_state)
      IDLE: if (can_enq) begin
        ing_next = ENQ;
        data_nxt = data_in;
      end
      ENQ:     ing_next = ACK;
      ACK:     if (!rdy_s) ing_next = IDLE;
      default: ing_next = IDLE;
    endcase

    // len_in has already settled in E_WAIT, so it can launch the next dequeue.
    can_deq = (len_in != '0) && (drain_in || (len_in >= THRESH_L)) &&
              (ing_next != ENQ) && (ing_state != ENQ);

    unique case (egr_state)
      E_IDLE:  egr_next = can_deq ? E_DEQ : E_IDLE;
      E_DEQ:   egr_next = E_WAIT;
      E_WAIT:  egr_next = can_deq ? E_DEQ : E_IDLE;
      default: egr_next = E_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock_10KHZ or negedge reset) begin
    if (!reset) begin
      ing_state   <= IDLE;
      egr_state   <= E_IDLE;
      ack_out     <= 1'b0;
      enqueue_out <= 1'b0;
      dequeue_out <= 1'b0;
      stall_out   <= 1'b0;
      data_out    <= '0;
    end else begin
      ing_state   <= ing_next;
      egr_state   <= egr_next;
      ack_out     <= (ing_next == ACK);
      enqueue_out <= (ing_next == ENQ);
      dequeue_out <= (egr_next == E_DEQ);
      stall_out   <= stall_nxt;
      data_out    <= data_nxt;
    end
  end

endmodule

// File: tb/tb_queue_ctrl.sv
// Directed bench for queue_ctrl: instance 0 uses THRESH=9, instance 1 THRESH=6.
// Each instance has a small queue-occupancy model driving len_in.
module tb_queue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rdy   [2];
  logic [7:0] din   [2];
  logic       ack   [2];
  logic       enq   [2];
  logic [7:0] dout  [2];
  logic [3:0] len   [2];
  logic       drain [2];
  logic       deq   [2];
  logic       stall [2];

  int checks = 0;
  int errors = 0;
  int enq_cnt [2];
  int deq_cnt [2];
  logic viol = 1'b0;

  always #5 clk = ~clk;

  queue_ctrl #(.DATA_W(8), .DEPTH(8), .LEN_W(4), .THRESH(9)) u_q0 (
    .clock_10KHZ(clk), .reset(rst_n), .data_ready_in(rdy[0]), .data_in(din[0]),
    .ack_out(ack[0]), .enqueue_out(enq[0]), .data_out(dout[0]), .len_in(len[0]),
    .drain_in(drain[0]), .dequeue_out(deq[0]), .stall_out(stall[0]));

  queue_ctrl #(.DATA_W(8), .DEPTH(8), .LEN_W(4), .THRESH(6)) u_q1 (
    .clock_10KHZ(clk), .reset(rst_n), .data_ready_in(rdy[1]), .data_in(din[1]),
    .ack_out(ack[1]), .enqueue_out(enq[1]), .data_out(dout[1]), .len_in(len[1]),
    .drain_in(drain[1]), .dequeue_out(deq[1]), .stall_out(stall[1]));

  // Queue occupancy model: len_in changes the cycle after a strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len[0] <= 4'd0;
      len[1] <= 4'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (enq[i])      len[i] <= len[i] + 4'd1;
        else if (deq[i]) len[i] <= len[i] - 4'd1;
      end
    end
  end

  // Strobe counters and sticky protocol-violation flag.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (enq[i]) enq_cnt[i] <= enq_cnt[i] + 1;
      if (deq[i]) deq_cnt[i] <= deq_cnt[i] + 1;
      if (rst_n && enq[i] && deq[i])        viol <= 1'b1;
      if (rst_n && enq[i] && len[i] >= 4'd8) viol <= 1'b1;
      if (rst_n && deq[i] && len[i] == 4'd0) viol <= 1'b1;
    end
  end

  ap_excl0: assert property (@(posedge clk) disable iff (!rst_n) !(enq[0] && deq[0]));
  ap_excl1: assert property (@(posedge clk) disable iff (!rst_n) !(enq[1] && deq[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int d, input logic v, input string tag);
    for (int i = 0; i < 40; i++) begin
      if (ack[d] === v) break;
      tick(1);
    end
    chk(tag, 32'(ack[d]), 32'(v));
  endtask

  task automatic send(input int d, input logic [7:0] w);
    rdy[d] = 1'b1;
    din[d] = w;
    wait_ack(d, 1'b1, "send_ack_rise");
    chk("send_data", 32'(dout[d]), 32'(w));
    rdy[d] = 1'b0;
    wait_ack(d, 1'b0, "send_ack_fall");
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rdy[i] = 1'b0; din[i] = 8'h00; drain[i] = 1'b0;
      enq_cnt[i] = 0; deq_cnt[i] = 0;
    end
    #1;
    chk("rst_async_ack", 32'(ack[1]), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack",   32'(ack[d]),   32'd0);
      chk("rst_enq",   32'(enq[d]),   32'd0);
      chk("rst_deq",   32'(deq[d]),   32'd0);
      chk("rst_stall", 32'(stall[d]), 32'd0);
      chk("rst_dout",  32'(dout[d]),  32'd0);
    end

    // Single word 0xA5 into an empty queue: latency and 4-phase ack.
    rdy[1] = 1'b1; din[1] = 8'hA5;
    tick(2);
    chk("a5_enq_early", 32'(enq[1]), 32'd0);
    tick(1);
    chk("a5_enq",  32'(enq[1]),  32'd1);
    chk("a5_data", 32'(dout[1]), 32'hA5);
    chk("a5_ack_pre", 32'(ack[1]), 32'd0);
    tick(1);
    chk("a5_enq_once", 32'(enq[1]), 32'd0);
    chk("a5_ack", 32'(ack[1]), 32'd1);
    rdy[1] = 1'b0;
    tick(2);
    chk("a5_ack_hold", 32'(ack[1]), 32'd1);
    tick(1);
    chk("a5_ack_drop", 32'(ack[1]), 32'd0);
    chk("a5_len", 32'(len[1]), 32'd1);
    chk("a5_no_deq", 32'(deq_cnt[1]), 32'd0);

    // THRESH=6: five more words; one dequeue at len 6, settles at 5.
    for (int i = 0; i < 5; i++) send(1, 8'h20 + 8'(i));
    tick(5);
    chk("th_deq_cnt", 32'(deq_cnt[1]), 32'd1);
    chk("th_len", 32'(len[1]), 32'd5);

    // Drain 5 words: dequeue every other cycle, then none when empty.
    drain[1] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      chk("drain_pattern", 32'(deq[1]), ((i % 2 == 1) && (i <= 9)) ? 32'd1 : 32'd0);
    end
    chk("drain_len", 32'(len[1]), 32'd0);
    drain[1] = 1'b0;

    // Three words queued then drain: exactly three dequeues.
    for (int i = 0; i < 3; i++) send(1, 8'h40 + 8'(i));
    base = deq_cnt[1];
    drain[1] = 1'b1;
    tick(20);
    chk("drain3_cnt", 32'(deq_cnt[1] - base), 32'd3);
    chk("drain3_len", 32'(len[1]), 32'd0);
    drain[1] = 1'b0;

    // Contention: ready word and dequeue eligibility decided in the same cycle.
    send(1, 8'h55);
    rdy[1] = 1'b1; din[1] = 8'h3C;
    tick(2);
    drain[1] = 1'b1;
    tick(1);
    chk("cont_enq",  32'(enq[1]),  32'd1);
    chk("cont_deq0", 32'(deq[1]),  32'd0);
    chk("cont_data", 32'(dout[1]), 32'h3C);
    tick(1);
    chk("cont_deq1", 32'(deq[1]), 32'd0);
    tick(1);
    chk("cont_deq2", 32'(deq[1]), 32'd1);
    chk("cont_enq2", 32'(enq[1]), 32'd0);
    rdy[1] = 1'b0;
    wait_ack(1, 1'b0, "cont_ack_fall");
    tick(8);
    chk("cont_len", 32'(len[1]), 32'd0);
    drain[1] = 1'b0;

    // THRESH=9: fill to 8, ninth word stalls until one drain dequeue.
    for (int i = 0; i < 8; i++) send(0, 8'h10 + 8'(i));
    chk("fill_len", 32'(len[0]), 32'd8);
    chk("fill_no_deq", 32'(deq_cnt[0]), 32'd0);
    base = enq_cnt[0];
    rdy[0] = 1'b1; din[0] = 8'h99;
    tick(6);
    chk("full_stall", 32'(stall[0]), 32'd1);
    chk("full_ack",   32'(ack[0]),   32'd0);
    chk("full_noenq", 32'(enq_cnt[0] - base), 32'd0);
    chk("full_len",   32'(len[0]),   32'd8);
    drain[0] = 1'b1;
    tick(1);
    chk("full_deq", 32'(deq[0]), 32'd1);
    drain[0] = 1'b0;
    tick(1);
    chk("full_deq_once", 32'(deq[0]), 32'd0);
    chk("full_stall2", 32'(stall[0]), 32'd1);
    tick(1);
    chk("full_enq9",   32'(enq[0]),   32'd1);
    chk("full_data9",  32'(dout[0]),  32'h99);
    chk("full_unstall", 32'(stall[0]), 32'd0);
    wait_ack(0, 1'b1, "full_ack_rise");
    rdy[0] = 1'b0;
    wait_ack(0, 1'b0, "full_ack_fall");
    tick(4);
    chk("full_len_end", 32'(len[0]), 32'd8);
    chk("full_deq_total", 32'(deq_cnt[0]), 32'd1);

    // Reset during ACK: outputs clear at once; held word re-accepted afterwards.
    rdy[1] = 1'b1; din[1] = 8'h77;
    wait_ack(1, 1'b1, "rack_rise");
    rst_n = 1'b0;
    #1;
    chk("rmid_ack",  32'(ack[1]),  32'd0);
    chk("rmid_enq",  32'(enq[1]),  32'd0);
    chk("rmid_deq",  32'(deq[1]),  32'd0);
    chk("rmid_dout", 32'(dout[1]), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("rrel_enq_early", 32'(enq[1]), 32'd0);
    tick(1);
    chk("rrel_enq",  32'(enq[1]),  32'd1);
    chk("rrel_data", 32'(dout[1]), 32'h77);
    wait_ack(1, 1'b1, "rrel_ack_rise");
    rdy[1] = 1'b0;
    wait_ack(1, 1'b0, "rrel_ack_fall");
    chk("rrel_len", 32'(len[1]), 32'd1);

    chk("protocol_ok", 32'(viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
